phase_sequencer: RTL and testbench

Cycle-phase controller for the CPU core. It generates the one-hot FETCH/EXEC1/EXEC2/EXEC3 phase strobes consumed by the address decoder and owns the instruction register and the latched old-opcode field. Instruction length is 2, 3 or 4 cycles, chosen from the opcode captured at FETCH. The block also handles STP halting and keeps a retired-instruction counter. It sits between the RAM data bus and the decode/datapath control logic.

---
 rtl/phase_sequencer_pkg.sv | 21 ++
 rtl/phase_sequencer_ir_register.sv | 25 ++
 rtl/phase_sequencer.sv | 123 ++++++++++++
 tb/tb_phase_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared CPU constants and phase-sequencer state encoding.
// Optional macro STEP_CTRL_EN adds the single-step wait state.
package phase_sequencer_pkg;

  localparam logic [3:0] OP_LDN = 4'h9;
  localparam logic [3:0] OP_RET = 4'hF;
  localparam logic [3:0] OP_SSS = 4'hA;
  localparam logic [7:0] OP_STP = 8'hA0;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_EXEC3 = 3'd3,
`ifdef STEP_CTRL_EN
    S_WAIT  = 3'd5,
`endif
    S_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/phase_sequencer_ir_register.sv
// Instruction register plus the old-opcode latch captured at FETCH.
module phase_sequencer_ir_register (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        ir_load,
  input  logic        old_load,
  output logic [15:0] ir,
  output logic [3:0]  old_opcode
);

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= 16'h0000;
      old_opcode <= 4'h0;
    end else begin
      if (ir_load)
        ir <= ir_in;
      if (old_load)
        old_opcode <= ir_in[15:12];
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// CPU cycle-phase controller: one-hot phase strobes, IR ownership, STP halt
// and retired-instruction counter. Macro STEP_CTRL_EN adds step_mode/step.
module phase_sequencer
  import phase_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IR_in,
  input  logic        ldn_reload,
`ifdef STEP_CTRL_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  output logic        FETCH,
  output logic        EXEC1,
  output logic        EXEC2,
  output logic        EXEC3,
  output logic        IR_load,
  output logic [7:0]  IR_opcode,
  output logic [7:0]  IR_operand,
  output logic [3:0]  IR_oldopcode,
  output logic        HALTED,
  output logic [15:0] instr_count
);

  state_t      state;
  state_t      state_nxt;
  state_t      fetch_entry;
  logic        retire;
  logic        is_ldn;
  logic        is_ret;
  logic [15:0] ir;

  // Length class comes from the latched old opcode; the live IR may be
  // overwritten by an LDN reload.
  assign is_ldn = (IR_oldopcode == OP_LDN);
  assign is_ret = (IR_oldopcode == OP_RET);

  assign IR_load = (state == S_FETCH) ||
                   (is_ldn && ldn_reload &&
                    ((state == S_EXEC1) || (state == S_EXEC2)));

  assign IR_opcode  = ir[15:8];
  assign IR_operand = ir[7:0];

`ifdef STEP_CTRL_EN
  assign fetch_entry = step_mode ? S_WAIT : S_FETCH;
`else
  assign fetch_entry = S_FETCH;
`endif

  phase_sequencer_ir_register u_ir (
    .clk        (CLK),
    .reset      (RESET),
    .ir_in      (IR_in),
    .ir_load    (IR_load),
    .old_load   (state == S_FETCH),
    .ir         (ir),
    .old_opcode (IR_oldopcode)
  );

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      S_FETCH: state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (is_ldn || is_ret) begin
          state_nxt = S_EXEC2;
        end else if (IR_opcode == OP_STP) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else begin
          state_nxt = fetch_entry;
          retire    = 1'b1;
        end
      end
      S_EXEC2: begin
        if (is_ldn) begin
          state_nxt = S_EXEC3;
        end else begin
          state_nxt = fetch_entry;
          retire    = 1'b1;
        end
      end
      S_EXEC3: begin
        state_nxt = fetch_entry;
        retire    = 1'b1;
      end
`ifdef STEP_CTRL_EN
      S_HALT: if (step) state_nxt = S_FETCH;
      S_WAIT: if (step) state_nxt = S_FETCH;
`else
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Phase strobes are registered decodes of the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_FETCH;
      FETCH       <= 1'b1;
      EXEC1       <= 1'b0;
      EXEC2       <= 1'b0;
      EXEC3       <= 1'b0;
      HALTED      <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      state  <= state_nxt;
      FETCH  <= (state_nxt == S_FETCH);
      EXEC1  <= (state_nxt == S_EXEC1);
      EXEC2  <= (state_nxt == S_EXEC2);
      EXEC3  <= (state_nxt == S_EXEC3);
      HALTED <= (state_nxt == S_HALT);
      if (retire)
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed table-driven bench for phase_sequencer, plus hand sequences for
// halt, reset during LDN, counter wrap and (with STEP_CTRL_EN) stepping.
module tb_phase_sequencer;

  logic        CLK;
  logic        RESET;
  logic [15:0] IR_in;
  logic        ldn_reload;
  logic        FETCH, EXEC1, EXEC2, EXEC3;
  logic        IR_load;
  logic [7:0]  IR_opcode;
  logic [7:0]  IR_operand;
  logic [3:0]  IR_oldopcode;
  logic        HALTED;
  logic [15:0] instr_count;
`ifdef STEP_CTRL_EN
  logic        step_mode;
  logic        step;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] PH_F  = 5'b10000;
  localparam logic [4:0] PH_E1 = 5'b01000;
  localparam logic [4:0] PH_E2 = 5'b00100;
  localparam logic [4:0] PH_E3 = 5'b00010;
  localparam logic [4:0] PH_H  = 5'b00001;
  localparam logic [4:0] PH_W  = 5'b00000;

  typedef struct {
    logic        rst;
    logic [15:0] ir_in;
    logic        reload;
    logic        exp_load;
    logic [4:0]  exp_ph;
    logic [7:0]  exp_op;
    logic [7:0]  exp_opd;
    logic [3:0]  exp_old;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [17];

  phase_sequencer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IR_in        (IR_in),
    .ldn_reload   (ldn_reload),
`ifdef STEP_CTRL_EN
    .step_mode    (step_mode),
    .step         (step),
`endif
    .FETCH        (FETCH),
    .EXEC1        (EXEC1),
    .EXEC2        (EXEC2),
    .EXEC3        (EXEC3),
    .IR_load      (IR_load),
    .IR_opcode    (IR_opcode),
    .IR_operand   (IR_operand),
    .IR_oldopcode (IR_oldopcode),
    .HALTED       (HALTED),
    .instr_count  (instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] phases();
    return {FETCH, EXEC1, EXEC2, EXEC3, HALTED};
  endfunction

  task automatic drive(input logic rst, input logic [15:0] ir, input logic rl);
    RESET      = rst;
    IR_in      = ir;
    ldn_reload = rl;
  endtask

  initial begin
    //            rst  ir_in     rl  load phase  op     opd    old   cnt
    vecs[0]  = '{1'b0, 16'h0012, 1'b0, 1'b1, PH_E1, 8'h00, 8'h12, 4'h0, 16'd0};
    vecs[1]  = '{1'b0, 16'h0012, 1'b0, 1'b0, PH_F,  8'h00, 8'h12, 4'h0, 16'd1};
    vecs[2]  = '{1'b0, 16'h9034, 1'b0, 1'b1, PH_E1, 8'h90, 8'h34, 4'h9, 16'd1};
    vecs[3]  = '{1'b0, 16'h2000, 1'b1, 1'b1, PH_E2, 8'h20, 8'h00, 4'h9, 16'd1};
    vecs[4]  = '{1'b0, 16'h5555, 1'b0, 1'b0, PH_E3, 8'h20, 8'h00, 4'h9, 16'd1};
    vecs[5]  = '{1'b0, 16'hF000, 1'b0, 1'b0, PH_F,  8'h20, 8'h00, 4'h9, 16'd2};
    vecs[6]  = '{1'b0, 16'hF000, 1'b0, 1'b1, PH_E1, 8'hF0, 8'h00, 4'hF, 16'd2};
    vecs[7]  = '{1'b0, 16'h1234, 1'b1, 1'b0, PH_E2, 8'hF0, 8'h00, 4'hF, 16'd2};
    vecs[8]  = '{1'b0, 16'h1234, 1'b0, 1'b0, PH_F,  8'hF0, 8'h00, 4'hF, 16'd3};
    vecs[9]  = '{1'b0, 16'h9034, 1'b0, 1'b1, PH_E1, 8'h90, 8'h34, 4'h9, 16'd3};
    vecs[10] = '{1'b0, 16'h7777, 1'b0, 1'b0, PH_E2, 8'h90, 8'h34, 4'h9, 16'd3};
    vecs[11] = '{1'b0, 16'h6600, 1'b1, 1'b1, PH_E3, 8'h66, 8'h00, 4'h9, 16'd3};
    vecs[12] = '{1'b0, 16'h6600, 1'b1, 1'b0, PH_F,  8'h66, 8'h00, 4'h9, 16'd4};
    vecs[13] = '{1'b0, 16'hA5FF, 1'b0, 1'b1, PH_E1, 8'hA5, 8'hFF, 4'hA, 16'd4};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, PH_F,  8'hA5, 8'hFF, 4'hA, 16'd5};
    vecs[15] = '{1'b0, 16'hA000, 1'b0, 1'b1, PH_E1, 8'hA0, 8'h00, 4'hA, 16'd5};
    vecs[16] = '{1'b0, 16'h1111, 1'b0, 1'b0, PH_H,  8'hA0, 8'h00, 4'hA, 16'd6};

`ifdef STEP_CTRL_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    drive(1'b1, 16'h0000, 1'b0);
    tick();
    check("reset_phase", 32'(phases()), 32'(PH_F));
    check("reset_count", 32'(instr_count), 32'h0);
    check("reset_ir", 32'({IR_opcode, IR_operand, IR_oldopcode}), 32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].ir_in, vecs[i].reload);
      #1;
      check($sformatf("v%0d_ir_load", i), 32'(IR_load), 32'(vecs[i].exp_load));
      tick();
      check($sformatf("v%0d_phase", i), 32'(phases()), 32'(vecs[i].exp_ph));
      check($sformatf("v%0d_ir", i), 32'({IR_opcode, IR_operand}),
            32'({vecs[i].exp_op, vecs[i].exp_opd}));
      check($sformatf("v%0d_oldop", i), 32'(IR_oldopcode), 32'(vecs[i].exp_old));
      check($sformatf("v%0d_count", i), 32'(instr_count), 32'(vecs[i].exp_cnt));
    end

    // HALT is absorbing for 20 cycles regardless of inputs.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 16'(i * 16'h1111), 1'(i));
      #1;
      check($sformatf("halt%0d_ir_load", i), 32'(IR_load), 32'h0);
      tick();
      check($sformatf("halt%0d_state", i),
            32'({phases(), IR_opcode, instr_count}), {3'b0, PH_H, 8'hA0, 16'd6});
    end

    drive(1'b1, 16'h9034, 1'b1);
    tick();
    check("halt_reset_phase", 32'(phases()), 32'(PH_F));
    check("halt_reset_state", 32'({IR_opcode, IR_oldopcode, instr_count}), 32'h0);

    // Reset asserted during LDN EXEC2.
    drive(1'b0, 16'h9034, 1'b0);
    tick();
    drive(1'b0, 16'h1234, 1'b0);
    tick();
    check("ldn_mid_e2", 32'(phases()), 32'(PH_E2));
    drive(1'b1, 16'h5678, 1'b1);
    tick();
    check("ldn_reset_phase", 32'(phases()), 32'(PH_F));
    check("ldn_reset_ir", 32'({IR_opcode, IR_operand, IR_oldopcode}), 32'h0);
    check("ldn_reset_count", 32'(instr_count), 32'h0);

    // Counter wrap from 16'hFFFF to 0.
    drive(1'b0, 16'h0012, 1'b0);
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    tick();
    check("wrap_pre", 32'({phases(), instr_count}), {11'b0, PH_E1, 16'hFFFF});
    tick();
    check("wrap_post", 32'({phases(), instr_count}), {11'b0, PH_F, 16'h0000});

`ifdef STEP_CTRL_EN
    drive(1'b1, 16'h0012, 1'b0);
    step_mode = 1'b1;
    tick();
    check("step_reset", 32'(phases()), 32'(PH_F));
    drive(1'b0, 16'h0012, 1'b0);
    tick();
    check("step_e1", 32'(phases()), 32'(PH_E1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("step_wait%0d", i), 32'({phases(), instr_count}), {11'b0, PH_W, 16'd1});
    end
    step = 1'b1;
    IR_in = 16'hF000;
    tick();
    check("step_go_f", 32'(phases()), 32'(PH_F));
    step = 1'b0;
    tick();
    check("step_ret_e1", 32'({phases(), IR_opcode}), {19'b0, PH_E1, 8'hF0});
    tick();
    check("step_ret_e2", 32'(phases()), 32'(PH_E2));
    tick();
    check("step_ret_wait", 32'({phases(), instr_count}), {11'b0, PH_W, 16'd2});
    step_mode = 1'b0;
    step = 1'b1;
    IR_in = 16'hA000;
    tick();
    check("step_nomode_f", 32'(phases()), 32'(PH_F));
    step = 1'b0;
    tick();
    tick();
    check("step_halt", 32'({phases(), instr_count}), {11'b0, PH_H, 16'd3});
    step = 1'b1;
    IR_in = 16'h0012;
    tick();
    check("step_resume", 32'({phases(), IR_opcode}), {19'b0, PH_F, 8'hA0});
    step = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
